sdram_block_writer: RTL and testbench
=====================================

Name: sdram_block_writer

Overview:
- Sits directly downstream of the FIFO-to-SDRAM read controller.
- Raises `sdram_rx_rdy` when a 1 KB block is announced, then captures the 16-bit words the FIFO outputs.
- Stages the words in a two-burst ping-pong buffer and issues fixed-length write bursts to the SDRAM controller core at an incrementing, wrapping address.
- Counts completed blocks and flags overruns.

Parameters:
DATA_WIDTH, 16, FIFO/SDRAM data word width
ADDR_WIDTH, 22, SDRAM word address width
WORDS_PER_BLOCK, 512, words transferred per block
BURST_LEN, 8, words per SDRAM write burst (power of 2; must divide WORDS_PER_BLOCK)
BASE_ADDR, 0, first write address and wrap target
ADDR_LIMIT, 4194304, address at or beyond which the write address wraps to BASE_ADDR

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
fifo_tx_rdy  in  1  upstream: a block of WORDS_PER_BLOCK words is available
fifo_rdreq  in  1  upstream FIFO read strobe; FIFO data is valid on the cycle after fifo_rdreq=1
fifo_q  in  DATA_WIDTH  FIFO output data
sdram_rx_rdy  out  1  to upstream: ready to receive a block
sdr_wr_req  out  1  burst write request to the SDRAM controller
sdr_wr_addr  out  ADDR_WIDTH  burst start address, stable while sdr_wr_req=1
sdr_wr_ack  in  1  one-cycle pulse: request accepted
sdr_wr_data_req  in  1  controller pulls one word per asserted cycle, after the ack
sdr_wr_data  out  DATA_WIDTH  current word, combinational from the buffer read pointer
blocks_written  out  16  count of fully written blocks, wraps at 65535->0
overrun  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0; write address=BASE_ADDR; buffer pointers, word count, block count and internal fifo_rdreq delay register cleared. Assertion mid-block abandons the block; any partial burst is discarded.
- Capture: word_valid = fifo_rdreq registered one cycle. When word_valid=1 in RECV, fifo_q is written to the buffer and the word count increments.
- Buffer: 2 x BURST_LEN words.
  - A half becomes "full" when its BURST_LEN-th word is written.
  - A half becomes "free" when its BURST_LEN-th word is pulled by sdr_wr_data_req.
  - A write to a half that is still full sets overrun=1 (sticky until reset); the word is dropped and does not advance the write pointer.
- State IDLE: sdram_rx_rdy=0. Go to RECV when fifo_tx_rdy=1 and both halves are free.
- State RECV: sdram_rx_rdy=1.
  - Stay until the word count reaches WORDS_PER_BLOCK and fifo_rdreq=0 on the same or a later cycle.
  - This holds sdram_rx_rdy through the upstream's trailing deassert cycle, so the upstream always finishes with fifo_rdreq=0.
  - Then go to FLUSH. Any word_valid seen after the count reaches WORDS_PER_BLOCK sets overrun and the word is dropped.
- State FLUSH: sdram_rx_rdy=0.
  - When both halves are free, go to IDLE.
  - In the same cycle: blocks_written increments, the word count clears, and the buffer pointers reset to half 0.
- Burst issue (independent of state): when the oldest half is full and no burst is outstanding, set sdr_wr_req=1 with sdr_wr_addr=current write address.
  - Hold both until sdr_wr_ack=1. sdr_wr_req drops the cycle after the ack.
  - The address advances by BURST_LEN on the ack. If the result is ≥ ADDR_LIMIT, it becomes BASE_ADDR.
  - After the ack, each sdr_wr_data_req=1 cycle advances the read pointer. After BURST_LEN pulls the burst is complete and the next full half may be requested on the following cycle.
  - sdr_wr_data_req outside an accepted burst is ignored.
- Throughput requirement on the controller: one burst completed per BURST_LEN captured words. Otherwise overrun asserts.
- Simultaneous capture-into-half-A and pull-from-half-B in one cycle is legal and must not corrupt either half.
- The block never issues a partial burst.

Test Plan:
1. Reset, fifo_tx_rdy=1, upstream model streams 512 words (0x0000..0x01FF), controller acks after 2 cycles and pulls continuously -> 64 bursts at addresses 0,8,..,504; data in order; blocks_written=1; overrun=0; sdram_rx_rdy falls after fifo_rdreq=0.
2. ADDR_LIMIT=1024, four back-to-back blocks -> third block's first burst at address 0; blocks_written=4.
3. Controller delays each ack 20 cycles -> overrun=1 by the third burst and stays 1 through block end; sdram_rx_rdy still deasserts normally.
4. reset_n pulsed low at word 300 -> all outputs 0 immediately; next block starts at BASE_ADDR with blocks_written=0.
5. fifo_tx_rdy=0 -> sdram_rx_rdy stays 0 for 1000 cycles; no sdr_wr_req issued.
6. Stray sdr_wr_data_req pulses while idle -> no pointer movement; next block's data is correct.

Source files
------------

// File: rtl/sdram_block_writer.sv
// sdram_block_writer: captures FIFO blocks into a ping-pong buffer and issues fixed-length SDRAM write bursts
module sdram_block_writer #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 22,
  parameter int WORDS_PER_BLOCK = 512,
  parameter int BURST_LEN       = 8,
  parameter int BASE_ADDR       = 0,
  parameter int ADDR_LIMIT      = 4194304
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_tx_rdy,
  input  logic                  fifo_rdreq,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  sdram_rx_rdy,
  output logic                  sdr_wr_req,
  output logic [ADDR_WIDTH-1:0] sdr_wr_addr,
  input  logic                  sdr_wr_ack,
  input  logic                  sdr_wr_data_req,
  output logic [DATA_WIDTH-1:0] sdr_wr_data,
  output logic [15:0]           blocks_written,
  output logic                  overrun
);
  localparam int PW = $clog2(2 * BURST_LEN);
  localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
  localparam logic [PW-2:0]       LAST = (PW-1)'(BURST_LEN - 1);
  localparam logic [CW-1:0]       WPB  = CW'(WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH:0] LIM  = (ADDR_WIDTH+1)'(ADDR_LIMIT);
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  state_t                state, state_nxt;
  logic                  word_valid;
  logic                  active;
  logic [1:0]            full;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         word_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [DATA_WIDTH-1:0] mem [2*BURST_LEN];
  logic                  cap, drop, wr_en, last_wr, pull, last_pull, done_blk;

  // Decode capture/pull events, next state and block-level handshakes
  always_comb begin
    cap          = state == RECV && word_valid;
    drop         = cap && (word_cnt == WPB || full[wr_ptr[PW-1]]);
    wr_en        = cap && !drop;
    last_wr      = wr_en && wr_ptr[PW-2:0] == LAST;
    pull         = active && sdr_wr_data_req;
    last_pull    = pull && rd_ptr[PW-2:0] == LAST;
    done_blk     = state == FLUSH && full == 2'b00;
    addr_sum     = {1'b0, wr_addr} + STEP;
    sdram_rx_rdy = state == RECV;
    sdr_wr_data  = mem[rd_ptr];
    state_nxt    = (state == IDLE && fifo_tx_rdy && full == 2'b00) ? RECV :
                   (state == RECV && word_cnt == WPB && !fifo_rdreq) ? FLUSH :
                   done_blk ? IDLE : state;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;

  // Buffer fill/drain, burst handshake, address and block bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_valid     <= 1'b0;
      active         <= 1'b0;
      full           <= 2'b00;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      word_cnt       <= '0;
      wr_addr        <= BASE;
      sdr_wr_req     <= 1'b0;
      sdr_wr_addr    <= '0;
      blocks_written <= '0;
      overrun        <= 1'b0;
      for (int i = 0; i < 2 * BURST_LEN; i++) mem[i] <= '0;
    end else begin
      word_valid <= fifo_rdreq;
      if (drop) overrun <= 1'b1;
      if (cap && word_cnt != WPB) word_cnt <= word_cnt + 1'b1;
      if (wr_en) begin
        mem[wr_ptr] <= fifo_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (last_wr) full[wr_ptr[PW-1]] <= 1'b1;
      if (pull) rd_ptr <= rd_ptr + 1'b1;
      if (last_pull) begin
        full[rd_ptr[PW-1]] <= 1'b0;
        active             <= 1'b0;
      end
      if (!sdr_wr_req && !active && full[rd_ptr[PW-1]]) begin
        sdr_wr_req  <= 1'b1;
        sdr_wr_addr <= wr_addr;
      end
      if (sdr_wr_req && sdr_wr_ack) begin
        sdr_wr_req <= 1'b0;
        active     <= 1'b1;
        wr_addr    <= addr_sum >= LIM ? BASE : addr_sum[ADDR_WIDTH-1:0];
      end
      if (done_blk) begin
        blocks_written <= blocks_written + 16'd1;
        word_cnt       <= '0;
        wr_ptr         <= '0;
        rd_ptr         <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_block_writer.sv
// tb_sdram_block_writer: directed table-driven bench with upstream FIFO and SDRAM controller models
module tb_sdram_block_writer;
  logic        clk = 1'b0, reset_n = 1'b0, fifo_tx_rdy = 1'b0, fifo_rdreq = 1'b0;
  logic        sdr_wr_ack = 1'b0, sdr_wr_data_req = 1'b0;
  logic [15:0] fifo_q = '0;
  logic        sdram_rx_rdy, sdr_wr_req, overrun;
  logic [21:0] sdr_wr_addr;
  logic [15:0] sdr_wr_data, blocks_written;

  typedef struct {
    int delay;
    bit chk_data;
    int exp_blocks;
    int exp_ovr;
    int first;
    int bursts;
  } vec_t;

  int          checks = 0, errors = 0;
  int          ack_dly = 2;
  bit          stray = 1'b0;
  int          next_q = 0;
  int          cstate = 0, cnt = 0, pulls = 0;
  logic [21:0] addr_q[$];
  logic [15:0] data_q[$];
  vec_t        tbl[5];

  always #5 clk = ~clk;

  sdram_block_writer #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_tx_rdy(fifo_tx_rdy), .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q), .sdram_rx_rdy(sdram_rx_rdy), .sdr_wr_req(sdr_wr_req),
    .sdr_wr_addr(sdr_wr_addr), .sdr_wr_ack(sdr_wr_ack), .sdr_wr_data_req(sdr_wr_data_req),
    .sdr_wr_data(sdr_wr_data), .blocks_written(blocks_written), .overrun(overrun)
  );

  // SDRAM controller model: ack after ack_dly cycles, then pull a full burst; logs addresses and data
  always @(posedge clk) begin
    #1;
    sdr_wr_ack = 1'b0;
    sdr_wr_data_req = 1'b0;
    if (!reset_n) cstate = 0;
    else case (cstate)
      0: begin
        sdr_wr_data_req = stray;
        if (sdr_wr_req) begin
          addr_q.push_back(sdr_wr_addr);
          cnt = ack_dly;
          cstate = 1;
        end
      end
      1: if (cnt == 0) begin
        sdr_wr_ack = 1'b1;
        pulls = 0;
        cstate = 2;
      end else cnt--;
      default: if (pulls < 8) begin
        sdr_wr_data_req = 1'b1;
        data_q.push_back(sdr_wr_data);
        pulls++;
      end else cstate = 0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rx_rdy"}, 32'(sdram_rx_rdy), 0);
    chk({tag, "_wr_req"}, 32'(sdr_wr_req), 0);
    chk({tag, "_wr_addr"}, 32'(sdr_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(sdr_wr_data), 0);
    chk({tag, "_blocks"}, 32'(blocks_written), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    next_q = 0;
  endtask

  task automatic start_block();
    int t = 0;
    fifo_tx_rdy = 1'b1;
    while (!sdram_rx_rdy && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rx_rdy_rise", 32'(sdram_rx_rdy), 1);
    fifo_tx_rdy = 1'b0;
  endtask

  task automatic send(input int n);
    for (int w = 0; w < n; w++) begin
      fifo_rdreq = 1'b1;
      @(posedge clk);
      #1;
      fifo_rdreq = 1'b0;
      fifo_q = 16'(next_q);
      next_q++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_block(input int first, input int bursts, input bit chk_d);
    int ab = addr_q.size();
    int db = data_q.size();
    int q0 = next_q;
    int t = 0;
    logic [15:0] b0 = blocks_written;
    start_block();
    send(512);
    chk("rx_rdy_hold", 32'(sdram_rx_rdy), 1);
    @(posedge clk);
    #1;
    chk("rx_rdy_fall", 32'(sdram_rx_rdy), 0);
    while (blocks_written == b0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("block_done", 32'(blocks_written != b0), 1);
    if (bursts != 0) chk("burst_count", 32'(addr_q.size() - ab), 32'(bursts));
    for (int i = 0; i < addr_q.size() - ab; i++)
      chk("burst_addr", 32'(addr_q[ab+i]), 32'((first + 8 * i) % 1024));
    if (chk_d) begin
      chk("data_count", 32'(data_q.size() - db), 512);
      for (int i = 0; i < data_q.size() - db; i++)
        chk("burst_data", 32'(data_q[db+i]), 32'(q0 + i));
    end
  endtask

  initial begin
    int vrx, vreq;
    tbl[0] = '{2, 1'b1, 1, 0, 0, 64};
    tbl[1] = '{2, 1'b1, 2, 0, 512, 64};
    tbl[2] = '{2, 1'b1, 3, 0, 0, 64};
    tbl[3] = '{2, 1'b1, 4, 0, 512, 64};
    tbl[4] = '{20, 1'b0, 5, 1, 0, 0};
    #2;
    chk_zero_outputs("reset");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ack_dly = tbl[i].delay;
      run_block(tbl[i].first, tbl[i].bursts, tbl[i].chk_data);
      chk("tbl_blocks", 32'(blocks_written), 32'(tbl[i].exp_blocks));
      chk("tbl_overrun", 32'(overrun), 32'(tbl[i].exp_ovr));
    end
    ack_dly = 2;
    do_reset();
    start_block();
    send(300);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    next_q = 0;
    run_block(0, 64, 1'b1);
    chk("midreset_blocks", 32'(blocks_written), 1);
    chk("midreset_overrun", 32'(overrun), 0);
    do_reset();
    fifo_tx_rdy = 1'b0;
    vrx = 0;
    vreq = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (sdram_rx_rdy) vrx++;
      if (sdr_wr_req) vreq++;
    end
    chk("idle_rx_rdy_cycles", 32'(vrx), 0);
    chk("idle_wr_req_cycles", 32'(vreq), 0);
    stray = 1'b1;
    repeat (3) @(posedge clk);
    stray = 1'b0;
    repeat (2) @(posedge clk);
    stray = 1'b1;
    repeat (2) @(posedge clk);
    stray = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_wr_data", 32'(sdr_wr_data), 0);
    run_block(0, 64, 1'b1);
    chk("stray_blocks", 32'(blocks_written), 1);
    chk("stray_overrun", 32'(overrun), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
